// File: rtl/grid_pkg.sv
// Shared definitions for the grid memory write path.
// Holds the default grid address/data widths, the grid base addresses, the
// write-arbiter state encoding and the fixed requester slot assignment.
package grid_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  // Grid RAM layout: playfield cells from 0, next-piece preview from 240
  localparam logic [7:0] BOARD_BASE_ADDR      = 8'd0;
  localparam logic [7:0] NEXT_PIECE_BASE_ADDR = 8'd240;

  // Requester slots on the write arbiter
  localparam int REQ_PLACER    = 0;
  localparam int REQ_MOVER     = 1;
  localparam int REQ_CLEAR     = 2;
  localparam int REQ_BOARD_RST = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/grid_arb_rr_pick.sv
// Round-robin winner search (combinational).
// Scans req_i starting one slot after ptr_i, wrapping modulo NUM_REQ, and
// returns the first set request.
//   req_i  : request vector
//   ptr_i  : index of the most recently granted requester
//   win_o  : one-hot winner (zero when no request)
//   idx_o  : winner index
//   any_o  : at least one request present
module grid_arb_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               any_o
);

  always_comb begin : pick
    logic [PTR_W-1:0] ci;
    win_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    ci    = '0;
    // k = NUM_REQ wraps back to ptr itself, so the last holder is tried last
    for (int k = 1; k <= NUM_REQ; k++) begin
      ci = PTR_W'((int'(ptr_i) + k) % NUM_REQ);
      if (!any_o && req_i[ci]) begin
        win_o[ci] = 1'b1;
        idx_o     = ci;
        any_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/grid_write_arbiter.sv
// Grid RAM write-port arbiter.
// Shares the single grid RAM write port between NUM_REQ requesters (placer,
// mover, line clearer, board reset). Round-robin grant, locked for a whole
// burst, released by the holder's done pulse or by it dropping req. The
// holder's we/addr/data are registered onto mem_*; one RELEASE dead cycle
// separates bursts.
// Optional build macro GRID_ARB_TIMEOUT_EN: watchdog that revokes a grant in
// its TIMEOUT-th cycle and pulses timeout_err. Without it timeout_err is 0.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   req/done/req_we: per-requester request, burst-done pulse, write enable
//   req_addr/data  : packed per-requester address/data, slot i at [i*W +: W]
//   gnt            : registered one-hot grant
//   mem_we/addr/data: registered RAM write port
//   busy           : arbiter in GRANT or RELEASE
//   timeout_err    : one-cycle pulse on watchdog revocation
module grid_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        done,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_data,
  output logic                      busy,
  output logic                      timeout_err
);

  import grid_pkg::*;

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_t          state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;     // last winner; also the current holder in GRANT
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                to_q, to_d;

  logic [NUM_REQ-1:0]  win;
  logic [PTR_W-1:0]    win_idx;
  logic                win_any;
  logic                hold_rel;
  logic                wd_fire;

  grid_arb_rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .win_o (win),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  assign hold_rel = done[ptr_q] | ~req[ptr_q];

`ifdef GRID_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // GRANT is only entered from IDLE, so clearing in IDLE clears on entry.
  // cnt_q holds 0 in the first GRANT cycle; the TIMEOUT-th cycle fires.
  always_comb begin
    cnt_d   = cnt_q;
    wd_fire = 1'b0;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (state_q == GRANT) begin
      if (cnt_q == CNT_W'(TIMEOUT - 1)) wd_fire = 1'b1;
      else                              cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign wd_fire        = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    mem_we_d = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    to_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d = GRANT;
          gnt_d   = win;
          ptr_d   = win_idx;
        end
      end
      GRANT: begin
        // Release beats the write: the holder's we in its done cycle is dropped
        if (hold_rel) begin
          state_d = RELEASE;
          gnt_d   = '0;
        end else if (wd_fire) begin
          state_d = RELEASE;
          gnt_d   = '0;
          to_d    = 1'b1;
        end else begin
          mem_we_d = req_we[ptr_q];
          addr_d   = req_addr[ptr_q*ADDR_W +: ADDR_W];
          data_d   = req_data[ptr_q*DATA_W +: DATA_W];
        end
      end
      RELEASE: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= PTR_W'(NUM_REQ - 1);
      gnt_q    <= '0;
      mem_we_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      mem_we_q <= mem_we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      to_q     <= to_d;
    end
  end

  assign gnt         = gnt_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = addr_q;
  assign mem_data    = data_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = to_q;

endmodule

// File: tb/tb_grid_write_arbiter.sv
module tb_grid_write_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, done, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_data;
  logic            busy;
  logic            timeout_err;

  always #5 clk = ~clk;

  grid_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done), .req_we(req_we),
    .req_addr(req_addr), .req_data(req_data), .gnt(gnt), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy), .timeout_err(timeout_err)
  );

  int n_chk = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int seen7 = 0;

  // Reference model: who holds the port, how many dead cycles remain,
  // who was served last, and how long the current grant has lasted.
  int            m_hold = -1;
  int            m_gap  = 0;
  int            m_last = N - 1;
  int            m_len  = 0;
  logic          m_we   = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic          m_to   = 1'b0;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] we;
    logic [N-1:0] e_gnt;
    logic         e_busy;
    logic         e_we;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    m_to = 1'b0;
    if (rst) begin
      m_hold = -1; m_gap = 0; m_last = N - 1;
      m_we = 1'b0; m_addr = '0; m_data = '0;
    end else if (m_hold >= 0) begin
      m_len++;
      if (((done >> m_hold) & 1) != 0 || ((req >> m_hold) & 1) == 0) begin
        m_hold = -1; m_gap = 1; m_we = 1'b0;
      end
`ifdef GRID_ARB_TIMEOUT_EN
      else if (m_len == TO) begin
        m_hold = -1; m_gap = 1; m_we = 1'b0; m_to = 1'b1;
      end
`endif
      else begin
        m_we   = ((req_we >> m_hold) & 1) != 0;
        m_addr = AW'(req_addr >> (m_hold * AW));
        m_data = DW'(req_data >> (m_hold * DW));
      end
    end else if (m_gap > 0) begin
      m_gap--;
      m_we = 1'b0;
    end else begin
      m_we = 1'b0;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (((req >> c) & 1) != 0) begin
          m_hold = c; m_last = c; m_len = 0;
          break;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("gnt", 32'(gnt), (m_hold >= 0) ? (32'(1) << m_hold) : 32'd0);
    chk("mem_we", 32'(mem_we), 32'(m_we));
    chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    chk("mem_data", 32'(mem_data), 32'(m_data));
    chk("busy", 32'(busy), (m_hold >= 0 || m_gap > 0) ? 32'd1 : 32'd0);
    chk("timeout_err", 32'(timeout_err), 32'(m_to));
    if (mem_we === 1'b1) begin
      wr_cnt++;
      if (mem_addr == 8'd7) seen7++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_gnt(input logic [1:0] idx);
    int t;
    t = 0;
    while (gnt == '0 && t < 30) begin
      tick();
      t++;
    end
    chk("grant_order", 32'(gnt), 32'(1) << idx);
  endtask

  task automatic burst(input logic [1:0] idx, input int n, input logic [AW-1:0] base,
                       input logic [DW-1:0] dat);
    wait_gnt(idx);
    for (int i = 0; i < n; i++) begin
      req_we[idx] = 1'b1;
      req_addr[idx*AW +: AW] = base + AW'(i);
      req_data[idx*DW +: DW] = dat;
      tick();
    end
    req_we[idx] = 1'b0;
    done[idx]   = 1'b1;
    tick();
    done[idx]   = 1'b0;
  endtask

  task automatic random_phase();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        logic [1:0] li;
        li = 2'(i);
        req_addr[i*AW +: AW] = AW'($urandom);
        req_data[i*DW +: DW] = DW'($urandom);
        req_we[li] = 1'($urandom_range(1, 0));
        if (gnt[li]) begin
          done[li] = ($urandom_range(5, 0) == 0);
          if ($urandom_range(24, 0) == 0) req[li] = 1'b0;
        end else begin
          done[li] = ($urandom_range(7, 0) == 0);
          if (!req[li])                         req[li] = ($urandom_range(3, 0) == 0);
          else if ($urandom_range(11, 0) == 0)  req[li] = 1'b0;
        end
      end
      rst = ($urandom_range(149, 0) == 0);
      tick();
    end
    rst = 1'b0; req = '0; done = '0; req_we = '0;
  endtask

  initial begin
    int n_hi, n_to;
    // Requesters 1 and 2 contend with ptr at 0: 1 first, RELEASE, IDLE, then 2
    //           req      done     we       e_gnt    busy  we
    tbl[0] = '{4'b0110, 4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b0};
    tbl[1] = '{4'b0110, 4'b0000, 4'b0010, 4'b0010, 1'b1, 1'b1};
    tbl[2] = '{4'b0110, 4'b0000, 4'b0010, 4'b0010, 1'b1, 1'b1};
    tbl[3] = '{4'b0110, 4'b0010, 4'b0010, 4'b0000, 1'b1, 1'b0};
    tbl[4] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[5] = '{4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b1, 1'b0};
    tbl[6] = '{4'b0100, 4'b0000, 4'b0100, 4'b0100, 1'b1, 1'b1};
    tbl[7] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0};
    tbl[8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};

    rst = 1'b1; req = '0; done = '0; req_we = '0; req_addr = '0; req_data = '0;
    tick();
    tick();
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_timeout_err", 32'(timeout_err), 32'd0);
    rst = 1'b0;

    // 12-write burst from the placer into the next-piece area
    wr_cnt = 0;
    req[0] = 1'b1;
    burst(2'd0, 12, grid_pkg::NEXT_PIECE_BASE_ADDR, 8'd1);
    chk("burst1_gnt_fall", 32'(gnt[0]), 32'd0);
    chk("burst1_busy_release", 32'(busy), 32'd1);
    req[0] = 1'b0;
    tick();
    chk("burst1_busy_fall", 32'(busy), 32'd0);
    chk("burst1_writes", 32'(wr_cnt), 32'd12);
    chk("burst1_last_addr", 32'(mem_addr), 32'd251);

    // Table: contention between 1 and 2
    req_addr[1*AW +: AW] = 8'h11; req_data[1*DW +: DW] = 8'h21;
    req_addr[2*AW +: AW] = 8'h12; req_data[2*DW +: DW] = 8'h22;
    for (int r = 0; r < 9; r++) begin
      req = tbl[r].req; done = tbl[r].done; req_we = tbl[r].we;
      tick();
      chk("tbl_gnt", 32'(gnt), 32'(tbl[r].e_gnt));
      chk("tbl_busy", 32'(busy), 32'(tbl[r].e_busy));
      chk("tbl_mem_we", 32'(mem_we), 32'(tbl[r].e_we));
    end
    done = '0; req_we = '0;

    // req[3] held, req[0] pulsing: 0,3,0,3
    do_reset();
    req[3] = 1'b1; req[0] = 1'b1;
    for (int r = 0; r < 2; r++) begin
      burst(2'd0, 1, 8'h40, 8'h01);
      req[0] = 1'b0;
      tick();
      req[0] = 1'b1;
      burst(2'd3, 1, 8'h43, 8'h03);
    end
    req = '0;
    repeat (3) tick();

    // Non-granted requester 2 drives garbage during 1's burst
    wr_cnt = 0; seen7 = 0;
    req[1] = 1'b1;
    req_we[2] = 1'b1; req_addr[2*AW +: AW] = 8'd7; done[2] = 1'b1;
    burst(2'd1, 5, 8'h30, 8'h55);
    req[1] = 1'b0; done[2] = 1'b0; req_we[2] = 1'b0;
    repeat (2) tick();
    chk("foreign_write_count", 32'(wr_cnt), 32'd5);
    chk("foreign_addr_seen", 32'(seen7), 32'd0);

    // Reset in the third write cycle of a burst
    req[0] = 1'b1;
    wait_gnt(2'd0);
    for (int i = 0; i < 3; i++) begin
      req_we[0] = 1'b1;
      req_addr[0*AW +: AW] = 8'h60 + 8'(i);
      if (i == 2) rst = 1'b1;
      tick();
    end
    chk("midrst_mem_we", 32'(mem_we), 32'd0);
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0; req_we = '0;
    req = 4'b0011;
    wait_gnt(2'd0);
    req = '0;
    repeat (3) tick();

`ifdef GRID_ARB_TIMEOUT_EN
    // Requester 0 never finishes; watchdog revokes, 1 is served next
    do_reset();
    req = 4'b0011;
    wait_gnt(2'd0);
    n_hi = 1; n_to = 0;
    for (int t = 0; t < 40 && gnt[0]; t++) begin
      tick();
      if (gnt[0]) n_hi++;
      if (timeout_err) n_to++;
    end
    tick();
    if (timeout_err) n_to++;
    chk("wd_grant_len", 32'(n_hi), 32'(TO));
    chk("wd_err_pulses", 32'(n_to), 32'd1);
    wait_gnt(2'd1);
    req = '0;
    repeat (3) tick();
`else
    n_hi = 0; n_to = 0;
`endif

    do_reset();
    random_phase();
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
